// File: rtl/id_ex_pipe_if.sv
// Decode-to-EX bundle for the ID/EX pipeline register.
// The master side is the decode stage; the slave side is the pipeline register.
interface id_ex_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned ALU_W  = 6,
  parameter int unsigned REG_AW = 5
);
  logic              stall_in;
  logic              flush;
  logic              id_valid;
  logic [CTRL_W-1:0] ctrl_in;
  logic [ALU_W-1:0]  alu_in;
  logic [DATA_W-1:0] busA_in;
  logic [DATA_W-1:0] busB_in;
  logic [DATA_W-1:0] imm_in;
  logic [2:0]        dmem_in;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] dst;
  logic              is_load;
  logic              ctl_xfer;
  logic              wb_we;
  logic [REG_AW-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;

  logic [CTRL_W-1:0] ctrl_q;
  logic [ALU_W-1:0]  alu_q;
  logic [DATA_W-1:0] busA_q;
  logic [DATA_W-1:0] busB_q;
  logic [DATA_W-1:0] imm_q;
  logic [2:0]        dmem_q;
  logic [REG_AW-1:0] dst_q;
  logic              load_q;
  logic              valid_q;
  logic              lock_if;
  logic [3:0]        bubble_cnt;

  modport master (
    output stall_in, flush, id_valid, ctrl_in, alu_in, busA_in, busB_in, imm_in,
           dmem_in, rs, rt, dst, is_load, ctl_xfer, wb_we, wb_reg, wb_data,
    input  ctrl_q, alu_q, busA_q, busB_q, imm_q, dmem_q, dst_q, load_q, valid_q,
           lock_if, bubble_cnt
  );

  modport slave (
    input  stall_in, flush, id_valid, ctrl_in, alu_in, busA_in, busB_in, imm_in,
           dmem_in, rs, rt, dst, is_load, ctl_xfer, wb_we, wb_reg, wb_data,
    output ctrl_q, alu_q, busA_q, busB_q, imm_q, dmem_q, dst_q, load_q, valid_q,
           lock_if, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion
// and a programmable bubble train after a taken jump/branch.
module id_ex_pipe #(
  parameter int unsigned      DATA_W  = 32,
  parameter int unsigned      CTRL_W  = 9,
  parameter int unsigned      ALU_W   = 6,
  parameter int unsigned      REG_AW  = 5,
  parameter int unsigned      BUBBLES = 3,
  parameter logic [ALU_W-1:0] NOP_ALU = ALU_W'(6'h15)
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_pipe_if.slave bus
);
  localparam int unsigned     CNT_W       = 4;
  localparam logic [CNT_W-1:0] BUBBLE_LOAD = CNT_W'(BUBBLES);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [ALU_W-1:0]  alu_q, alu_d;
  logic [DATA_W-1:0] bus_a_q, bus_a_d;
  logic [DATA_W-1:0] bus_b_q, bus_b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [2:0]        dmem_q, dmem_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic              load_q, load_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] bus_a_c, bus_b_c;
  logic              hz_c;

  // Same-cycle writeback forwarded onto the raw register-file read data
  always_comb begin
    bus_a_c = bus.busA_in;
    bus_b_c = bus.busB_in;
    if (bus.wb_we && (bus.wb_reg != '0) && (bus.wb_reg == bus.rs)) bus_a_c = bus.wb_data;
    if (bus.wb_we && (bus.wb_reg != '0) && (bus.wb_reg == bus.rt)) bus_b_c = bus.wb_data;
  end

  assign hz_c = bus.id_valid && valid_q && load_q && (dst_q != '0) &&
                ((dst_q == bus.rs) || (dst_q == bus.rt));

  assign bus.lock_if = bus.stall_in || hz_c || (cnt_q != '0);

  // Next state: a bubble unless held by stall or a valid instruction issues
  always_comb begin
    ctrl_d  = '0;
    alu_d   = NOP_ALU;
    bus_a_d = '0;
    bus_b_d = '0;
    imm_d   = '0;
    dmem_d  = '0;
    dst_d   = '0;
    load_d  = 1'b0;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      cnt_d = '0;
    end else if (bus.stall_in) begin
      ctrl_d  = ctrl_q;
      alu_d   = alu_q;
      bus_a_d = bus_a_q;
      bus_b_d = bus_b_q;
      imm_d   = imm_q;
      dmem_d  = dmem_q;
      dst_d   = dst_q;
      load_d  = load_q;
      valid_d = valid_q;
    end else if (hz_c) begin
      cnt_d = cnt_q;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (bus.id_valid) begin
      ctrl_d  = bus.ctrl_in;
      alu_d   = bus.alu_in;
      bus_a_d = bus_a_c;
      bus_b_d = bus_b_c;
      imm_d   = bus.imm_in;
      dmem_d  = bus.dmem_in;
      dst_d   = bus.dst;
      load_d  = bus.is_load;
      valid_d = 1'b1;
      cnt_d   = bus.ctl_xfer ? BUBBLE_LOAD : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      alu_q   <= NOP_ALU;
      bus_a_q <= '0;
      bus_b_q <= '0;
      imm_q   <= '0;
      dmem_q  <= '0;
      dst_q   <= '0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      bus_a_q <= bus_a_d;
      bus_b_q <= bus_b_d;
      imm_q   <= imm_d;
      dmem_q  <= dmem_d;
      dst_q   <= dst_d;
      load_q  <= load_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ctrl_q     = ctrl_q;
  assign bus.alu_q      = alu_q;
  assign bus.busA_q     = bus_a_q;
  assign bus.busB_q     = bus_b_q;
  assign bus.imm_q      = imm_q;
  assign bus.dmem_q     = dmem_q;
  assign bus.dst_q      = dst_q;
  assign bus.load_q     = load_q;
  assign bus.valid_q    = valid_q;
  assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: two instances (BUBBLES=3 and BUBBLES=0)
// driven with identical stimulus and checked against a reference model.
module tb_id_ex_pipe;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 9;
  localparam int unsigned AW = 6;
  localparam int unsigned RW = 5;
  localparam logic [5:0]  NOP = 6'h15;

  typedef struct packed {
    logic          rst;
    logic          stall;
    logic          flush;
    logic          id_valid;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] alu;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [2:0]    dmem;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dst;
    logic          is_load;
    logic          xfer;
    logic          wb_we;
    logic [RW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
  } in_t;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [AW-1:0] alu;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [2:0]    dmem;
    logic [RW-1:0] dst;
    logic          load;
    logic          valid;
    logic [3:0]    cnt;
  } st_t;

  logic clk = 1'b0;
  logic rst;
  in_t  cur_in = '0;

  always #5 clk = ~clk;

  id_ex_pipe_if #(.DATA_W(DW), .CTRL_W(CW), .ALU_W(AW), .REG_AW(RW)) if3 ();
  id_ex_pipe_if #(.DATA_W(DW), .CTRL_W(CW), .ALU_W(AW), .REG_AW(RW)) if0 ();

  id_ex_pipe #(.BUBBLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
  id_ex_pipe #(.BUBBLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));

  assign rst = cur_in.rst;
  assign {if3.stall_in, if0.stall_in} = {2{cur_in.stall}};
  assign {if3.flush,    if0.flush}    = {2{cur_in.flush}};
  assign {if3.id_valid, if0.id_valid} = {2{cur_in.id_valid}};
  assign {if3.ctrl_in,  if0.ctrl_in}  = {2{cur_in.ctrl}};
  assign {if3.alu_in,   if0.alu_in}   = {2{cur_in.alu}};
  assign {if3.busA_in,  if0.busA_in}  = {2{cur_in.a}};
  assign {if3.busB_in,  if0.busB_in}  = {2{cur_in.b}};
  assign {if3.imm_in,   if0.imm_in}   = {2{cur_in.imm}};
  assign {if3.dmem_in,  if0.dmem_in}  = {2{cur_in.dmem}};
  assign {if3.rs,       if0.rs}       = {2{cur_in.rs}};
  assign {if3.rt,       if0.rt}       = {2{cur_in.rt}};
  assign {if3.dst,      if0.dst}      = {2{cur_in.dst}};
  assign {if3.is_load,  if0.is_load}  = {2{cur_in.is_load}};
  assign {if3.ctl_xfer, if0.ctl_xfer} = {2{cur_in.xfer}};
  assign {if3.wb_we,    if0.wb_we}    = {2{cur_in.wb_we}};
  assign {if3.wb_reg,   if0.wb_reg}   = {2{cur_in.wb_reg}};
  assign {if3.wb_data,  if0.wb_data}  = {2{cur_in.wb_data}};

  st_t  q3[$];
  st_t  q0[$];
  logic lq3[$];
  logic lq0[$];
  st_t  m3;
  st_t  m0;
  bit   known = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  // Reference model: what the register presents after one edge
  function automatic st_t bubble();
    st_t s = '0;
    s.alu = NOP;
    return s;
  endfunction

  function automatic bit hazard(input st_t s, input in_t x);
    return x.id_valid && s.valid && s.load && (s.dst != 0) &&
           ((s.dst == x.rs) || (s.dst == x.rt));
  endfunction

  function automatic logic lock_m(input st_t s, input in_t x);
    return x.stall || hazard(s, x) || (s.cnt != 0);
  endfunction

  function automatic st_t model(input st_t s, input in_t x, input int bub);
    st_t n = bubble();
    if (x.rst || x.flush) return n;
    if (x.stall) return s;
    if (hazard(s, x)) begin
      n.cnt = s.cnt;
      return n;
    end
    if (s.cnt != 0) begin
      n.cnt = 4'(s.cnt - 1);
      return n;
    end
    if (!x.id_valid) return n;
    n.ctrl  = x.ctrl;
    n.alu   = x.alu;
    n.a     = (x.wb_we && x.wb_reg != 0 && x.wb_reg == x.rs) ? x.wb_data : x.a;
    n.b     = (x.wb_we && x.wb_reg != 0 && x.wb_reg == x.rt) ? x.wb_data : x.b;
    n.imm   = x.imm;
    n.dmem  = x.dmem;
    n.dst   = x.dst;
    n.load  = x.is_load;
    n.valid = 1'b1;
    n.cnt   = x.xfer ? 4'(bub) : 4'd0;
    return n;
  endfunction

  function automatic st_t get3();
    return {if3.ctrl_q, if3.alu_q, if3.busA_q, if3.busB_q, if3.imm_q, if3.dmem_q,
            if3.dst_q, if3.load_q, if3.valid_q, if3.bubble_cnt};
  endfunction

  function automatic st_t get0();
    return {if0.ctrl_q, if0.alu_q, if0.busA_q, if0.busB_q, if0.imm_q, if0.dmem_q,
            if0.dst_q, if0.load_q, if0.valid_q, if0.bubble_cnt};
  endfunction

  // Stimulus: apply one cycle of inputs and queue the expected responses
  task automatic cycle(input in_t x);
    @(negedge clk);
    cur_in = x;
    if (known) begin
      lq3.push_back(lock_m(m3, x));
      lq0.push_back(lock_m(m0, x));
    end
    m3 = model(m3, x, 3);
    m0 = model(m0, x, 0);
    if (x.rst) known = 1'b1;
    if (known) begin
      q3.push_back(m3);
      q0.push_back(m0);
    end
  endtask

  function automatic in_t idle();
    return '0;
  endfunction

  function automatic in_t rnd();
    in_t x;
    x.rst      = ($urandom_range(0, 59) == 0);
    x.stall    = ($urandom_range(0, 6) == 0);
    x.flush    = ($urandom_range(0, 19) == 0);
    x.id_valid = ($urandom_range(0, 4) != 0);
    x.ctrl     = CW'($urandom);
    x.alu      = AW'($urandom);
    x.a        = $urandom;
    x.b        = $urandom;
    x.imm      = $urandom;
    x.dmem     = 3'($urandom);
    x.rs       = RW'($urandom_range(0, 3));
    x.rt       = RW'($urandom_range(0, 3));
    x.dst      = RW'($urandom_range(0, 3));
    x.is_load  = ($urandom_range(0, 2) == 0);
    x.xfer     = ($urandom_range(0, 7) == 0);
    x.wb_we    = ($urandom_range(0, 1) == 0);
    x.wb_reg   = RW'($urandom_range(0, 3));
    x.wb_data  = $urandom;
    return x;
  endfunction

  // Monitor for registered outputs, sampled just after the active edge
  always begin
    @(posedge clk);
    #1;
    if (q3.size() != 0) begin
      st_t e3, e0, a3, a0;
      e3 = q3.pop_front();
      e0 = q0.pop_front();
      a3 = get3();
      a0 = get0();
      n_checks += 2;
      if (a3 !== e3) begin
        n_fail++;
        $display("FAIL regs_b3 t=%0t actual=%h expected=%h", $time, a3, e3);
      end
      if (a0 !== e0) begin
        n_fail++;
        $display("FAIL regs_b0 t=%0t actual=%h expected=%h", $time, a0, e0);
      end
    end
  end

  // Monitor for the combinational lock, sampled after inputs settle
  always begin
    @(negedge clk);
    #1;
    if (lq3.size() != 0) begin
      logic e3, e0;
      e3 = lq3.pop_front();
      e0 = lq0.pop_front();
      n_checks += 2;
      if (if3.lock_if !== e3) begin
        n_fail++;
        $display("FAIL lock_b3 t=%0t actual=%b expected=%b", $time, if3.lock_if, e3);
      end
      if (if0.lock_if !== e0) begin
        n_fail++;
        $display("FAIL lock_b0 t=%0t actual=%b expected=%b", $time, if0.lock_if, e0);
      end
    end
  end

  initial begin
    in_t x;
    in_t y;
    m3 = bubble();
    m0 = bubble();

    // Reset with random inputs
    x = rnd(); x.rst = 1'b1; cycle(x);
    x = rnd(); x.rst = 1'b1; cycle(x);
    cycle(idle());

    // Writeback bypass onto busA, then with register 0
    x = idle(); x.id_valid = 1'b1; x.rs = 5'd7; x.a = 32'h0;
    x.wb_we = 1'b1; x.wb_reg = 5'd7; x.wb_data = 32'hDEADBEEF;
    cycle(x);
    x.rs = 5'd0; x.wb_reg = 5'd0;
    cycle(x);
    cycle(idle());

    // Load-use: dependent instruction re-presented while locked
    x = idle(); x.id_valid = 1'b1; x.is_load = 1'b1; x.dst = 5'd3; x.alu = 6'h01;
    cycle(x);
    y = idle(); y.id_valid = 1'b1; y.rs = 5'd3; y.dst = 5'd4; y.alu = 6'h02;
    cycle(y);
    cycle(y);
    cycle(idle());

    // Taken jump followed by valid decode traffic
    x = idle(); x.id_valid = 1'b1; x.xfer = 1'b1; x.dst = 5'd31; x.imm = 32'h100;
    y = idle(); y.id_valid = 1'b1; y.dst = 5'd8; y.alu = 6'h0A;
    cycle(x);
    repeat (5) cycle(y);

    // Stall for two cycles when two bubbles remain
    cycle(x);
    cycle(y);
    y.stall = 1'b1;
    cycle(y);
    cycle(y);
    y.stall = 1'b0;
    repeat (5) cycle(y);

    // Flush wins over a concurrent taken transfer
    x.flush = 1'b1;
    cycle(x);
    cycle(y);
    cycle(y);

    // Reset in the middle of a bubble window
    x.flush = 1'b0;
    cycle(x);
    cycle(y);
    y.rst = 1'b1;
    cycle(y);
    y.rst = 1'b0;
    cycle(y);

    // Randomised traffic
    for (int i = 0; i < 800; i++) cycle(rnd());

    cycle(idle());
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q3.size() != 0 || lq3.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending expected=0 pending", q3.size() + lq3.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline register for the 32-bit five-stage core, placed between the decode logic (control unit, register file read, branch/jump target) and the EX stage. It registers decoded fields and bypasses same-cycle writeback data into the read buses. It detects load-use hazards and inserts a programmable number of bubbles after a taken control transfer, and drives the IF/ID hold signal. Bubble count, field widths and the NOP ALU code are parameters.

## Interface
- DATA_W, 32, width of busA/busB/imm
- CTRL_W, 9, width of control-signal vector
- ALU_W, 6, width of ALU control code
- REG_AW, 5, register index width
- BUBBLES, 3, bubbles inserted after a taken jump/branch (0..15)
- NOP_ALU, 6'h15, ALU code driven during a bubble

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- stall_in  in  1  downstream hold; freeze this register
- flush  in  1  kill in-flight decode and pending bubbles
- id_valid  in  1  decode-stage instruction is valid
- ctrl_in  in  CTRL_W  decoded control signals
- alu_in  in  ALU_W  decoded ALU control
- busA_in, busB_in  in  DATA_W  raw register-file read data
- imm_in  in  DATA_W  extended immediate
- dmem_in  in  3  load/store sign and size info
- rs, rt  in  REG_AW  source register indices
- dst  in  REG_AW  destination index (already muxed rd/rt/r31)
- is_load  in  1  instruction is a load
- ctl_xfer  in  1  taken jump or branch resolved in ID
- wb_we, wb_reg, wb_data  in  1/REG_AW/DATA_W  writeback port
- ctrl_q, alu_q, busA_q, busB_q, imm_q, dmem_q, dst_q  out  as inputs  registered fields
- load_q, valid_q  out  1  registered is_load / valid
- lock_if  out  1  hold IF and IF/ID (combinational)
- bubble_cnt  out  4  pending post-transfer bubbles

## Operation
- Bypass (combinational): busA = (wb_we && wb_reg!=0 && wb_reg==rs) ? wb_data : busA_in. busB is the same using rt.
- Hazard (combinational): hz = id_valid && valid_q && load_q && dst_q!=0 && (dst_q==rs || dst_q==rt).
- lock_if = stall_in || hz || (bubble_cnt!=0).
- Bubble content: ctrl_q=0, alu_q=NOP_ALU, valid_q=0, load_q=0, dst_q=0, busA_q=busB_q=imm_q=0, dmem_q=0.
- Per-edge priority, highest first:
  - rst: bubble content loaded, bubble_cnt=0.
  - flush: bubble content loaded, bubble_cnt=0. A ctl_xfer in the same cycle is discarded.
  - stall_in: all outputs and bubble_cnt hold.
  - hz: load a bubble; bubble_cnt holds. The decode instruction is re-presented next cycle because lock_if=1.
  - bubble_cnt!=0: load a bubble; bubble_cnt decrements by 1.
  - id_valid=0: load a bubble.
  - Otherwise (normal): register all fields, using bypassed buses, with valid_q=1. If ctl_xfer=1, bubble_cnt=BUBBLES.
- ctl_xfer is ignored unless the normal branch is taken. There is no re-arm while bubbles are pending.
- bubble_cnt is a plain down-counter. It never wraps below 0.
- BUBBLES=0: a taken transfer produces no bubbles and no lock.

## Timing
- Latency: 1 cycle, inputs to *_q.
- Reset values: every *_q=0 except alu_q=NOP_ALU. valid_q=0, bubble_cnt=0, lock_if=stall_in.
- Taken transfer at edge N: the transfer instruction appears at N+1. Bubbles appear at N+2..N+1+BUBBLES. lock_if=1 from after N until bubble_cnt returns to 0.
- Stall during the bubble window extends the window one cycle per stalled cycle.
- Load-use: exactly one bubble per load. The dependent instruction issues on the following edge, with the load's result forwarded downstream, not here.
- A writeback that coincides with a stall is not captured. The decode stage re-reads on release.
- Reset asserted mid-bubble-window: the counter clears on that edge and lock_if falls in the same cycle (if stall_in=0).

## Test plan
- Reset: rst=1 for 2 cycles with random inputs -> all *_q=0, alu_q=6'h15, valid_q=0, bubble_cnt=0, lock_if=0.
- Bypass: busA_in=32'h0, wb_we=1, wb_reg=rs=5'd7, wb_data=32'hDEADBEEF, valid instruction -> busA_q=32'hDEADBEEF next cycle. Repeat with wb_reg=0 -> busA_q=32'h0.
- Load-use: load with dst=5'd3 registered, next instruction rs=5'd3 -> lock_if=1 for one cycle, one bubble (valid_q=0, alu_q=6'h15), then the dependent instruction with valid_q=1.
- Control transfer, BUBBLES=3: jump with ctl_xfer=1 -> jump fields at N+1, then 3 bubbles. bubble_cnt reads 3,2,1,0. lock_if=1 for exactly 3 cycles.
- Stall inside the bubble window: stall_in=1 for 2 cycles when bubble_cnt=2 -> outputs and count frozen, total window extends by 2 cycles.
- Flush concurrent with ctl_xfer: flush=1 and ctl_xfer=1 -> bubble loaded, bubble_cnt=0, lock_if=0 next cycle. Also rerun the control-transfer case with BUBBLES=0 -> no bubbles, no lock.
